// File: rtl/id_ex_operand_stage_pkg.sv
// Shared datapath definitions for the ID/EX operand stage: widths, ALU select codes
// and the forwarding-source encoding reported on ex_fwd_a / ex_fwd_b.
package id_ex_operand_stage_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int SELECT_WIDTH = 3;
  localparam int REG_ADDR_W   = 5;

  localparam logic [2:0] ALU_NOT  = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_src_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode/writeback logic and the ID/EX operand stage.
interface id_ex_operand_stage_if
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int SW = SELECT_WIDTH,
  parameter int AW = REG_ADDR_W
);
  // Handshake: no ready signal. stall is the only back-pressure: while it is high the
  // stage ignores id_* and holds its contents; id_valid qualifies the decode slot and
  // ex_valid qualifies the EX slot. flush kills the slot entering EX and beats stall.
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_use_imm;
  logic [SW-1:0] id_alu_sel;
  logic [AW-1:0] id_rd_addr;
  logic          id_reg_write;
  logic          mem_reg_write;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_result;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd_addr;
  logic [DW-1:0] wb_result;
  logic          ex_valid;
  logic [DW-1:0] ex_in1;
  logic [DW-1:0] ex_in2;
  logic [SW-1:0] ex_alu_sel;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_reg_write;
  logic [1:0]    ex_fwd_a;
  logic [1:0]    ex_fwd_b;

  modport master (
    output stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_alu_sel, id_rd_addr, id_reg_write,
           mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
    input  ex_valid, ex_in1, ex_in2, ex_alu_sel, ex_rd_addr, ex_reg_write, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_alu_sel, id_rd_addr, id_reg_write,
           mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
    output ex_valid, ex_in1, ex_in2, ex_alu_sel, ex_rd_addr, ex_reg_write, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// One operand's forwarding mux: MEM beats WB beats the registered read; r0 never forwards.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = REG_ADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] value,
  output logic [1:0]    src
);
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == addr);
  assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == addr);

  always_comb begin
    value = reg_data;
    src   = FWD_REG;
    if (mem_hit) begin
      value = mem_result;
      src   = FWD_MEM;
    end else if (wb_hit) begin
      value = wb_result;
      src   = FWD_WB;
    end
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU inputs.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = id_ex_operand_stage_pkg::DATA_WIDTH,
  parameter int SELECT_WIDTH = id_ex_operand_stage_pkg::SELECT_WIDTH,
  parameter int REG_ADDR_W   = id_ex_operand_stage_pkg::REG_ADDR_W
) (
  input logic                 clk,
  input logic                 rst_n,
  id_ex_operand_stage_if.slave bus
);
  logic                    valid_q;
  logic [REG_ADDR_W-1:0]   rs_addr_q;
  logic [REG_ADDR_W-1:0]   rt_addr_q;
  logic [DATA_WIDTH-1:0]   rs_data_q;
  logic [DATA_WIDTH-1:0]   rt_data_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic                    use_imm_q;
  logic [SELECT_WIDTH-1:0] alu_sel_q;
  logic [REG_ADDR_W-1:0]   rd_addr_q;
  logic                    reg_write_q;
  logic [DATA_WIDTH-1:0]   fwd_a_val;
  logic [DATA_WIDTH-1:0]   fwd_b_val;
  logic [1:0]              fwd_a_src;
  logic [1:0]              fwd_b_src;
  logic                    wb_refresh_rs;
  logic                    wb_refresh_rt;

  // While stalled, absorb a retiring WB write into the held operand so it is not lost.
  assign wb_refresh_rs = bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == rs_addr_q);
  assign wb_refresh_rt = bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == rt_addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_sel_q   <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else if (bus.stall) begin
      if (bus.flush) valid_q <= 1'b0;
      if (wb_refresh_rs) rs_data_q <= bus.wb_result;
      if (wb_refresh_rt) rt_data_q <= bus.wb_result;
    end else begin
      valid_q     <= bus.id_valid & ~bus.flush;
      rs_addr_q   <= bus.id_rs_addr;
      rt_addr_q   <= bus.id_rt_addr;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      imm_q       <= bus.id_imm;
      use_imm_q   <= bus.id_use_imm;
      alu_sel_q   <= bus.id_alu_sel;
      rd_addr_q   <= bus.id_rd_addr;
      reg_write_q <= bus.id_reg_write;
    end
  end

  id_ex_operand_stage_fwd_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_W)) u_fwd_a (
    .addr(rs_addr_q), .reg_data(rs_data_q),
    .mem_reg_write(bus.mem_reg_write), .mem_rd_addr(bus.mem_rd_addr), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_rd_addr(bus.wb_rd_addr), .wb_result(bus.wb_result),
    .value(fwd_a_val), .src(fwd_a_src)
  );

  id_ex_operand_stage_fwd_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_W)) u_fwd_b (
    .addr(rt_addr_q), .reg_data(rt_data_q),
    .mem_reg_write(bus.mem_reg_write), .mem_rd_addr(bus.mem_rd_addr), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_rd_addr(bus.wb_rd_addr), .wb_result(bus.wb_result),
    .value(fwd_b_val), .src(fwd_b_src)
  );

  assign bus.ex_valid     = valid_q;
  assign bus.ex_in1       = fwd_a_val;
  assign bus.ex_in2       = use_imm_q ? imm_q : fwd_b_val;
  assign bus.ex_alu_sel   = alu_sel_q;
  assign bus.ex_rd_addr   = rd_addr_q;
  assign bus.ex_reg_write = reg_write_q & valid_q;
  assign bus.ex_fwd_a     = fwd_a_src;
  assign bus.ex_fwd_b     = use_imm_q ? 2'(FWD_REG) : fwd_b_src;
endmodule
